// File: rtl/hazard_stall_ctrl_if.sv
// Hazard controller bus: ID/EX hazard inputs and pipeline control outputs.
// The slave modport is the controller; the master modport is the datapath side.
interface hazard_stall_ctrl_if;
  logic [4:0] idRs;
  logic [4:0] idRt;
  logic       idUsesRt;
  logic [4:0] exRt;
  logic       exMemToReg;
  logic       exRegWrite;
  logic       idBranchTaken;
  logic       idMdStart;
  logic       idMdRead;
  logic       pcWrite;
  logic       ifIdWrite;
  logic       ifIdSyncClr;
  logic       idExSyncClr;
  logic       mdBusy;
  logic [1:0] stateOut;

  modport slave (
    input  idRs, idRt, idUsesRt, exRt, exMemToReg, exRegWrite,
           idBranchTaken, idMdStart, idMdRead,
    output pcWrite, ifIdWrite, ifIdSyncClr, idExSyncClr, mdBusy, stateOut
  );

  modport master (
    output idRs, idRt, idUsesRt, exRt, exMemToReg, exRegWrite,
           idBranchTaken, idMdStart, idMdRead,
    input  pcWrite, ifIdWrite, ifIdSyncClr, idExSyncClr, mdBusy, stateOut
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller for the 5-stage datapath.
// Stalls on load-use hazards and on HI/LO or mult/div use while the
// multi-cycle mult/div unit is busy; flushes IF/ID on taken branches.
// Optional macro HAZARD_STATS_EN adds saturating stall/flush counters.
module hazard_stall_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic                clock,
  input  logic                reset,
  hazard_stall_ctrl_if.slave  hz
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0]    stallCount,
  output logic [CNT_W-1:0]    flushCount
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1
  } mdState_t;

  // Counter reload: BUSY lasts MD_LATENCY cycles, counting down to zero.
  localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY - 1);

  mdState_t   state, stateNext;
  logic [3:0] cnt, cntNext;
  logic       loadUse;
  logic       mdStall;
  logic       stall;
  logic       flush;

  // Hazard detection; $zero as destination never creates a dependency.
  always_comb begin
    loadUse = hz.exMemToReg && hz.exRegWrite && (hz.exRt != 5'd0) &&
              ((hz.exRt == hz.idRs) || (hz.idUsesRt && (hz.exRt == hz.idRt)));
    mdStall = (state == BUSY) && (hz.idMdRead || hz.idMdStart);
    stall   = loadUse || mdStall;
    flush   = hz.idBranchTaken && !stall;
  end

  // Pipeline control outputs; all forced inactive while reset is asserted.
  always_comb begin
    hz.pcWrite     = !reset && !stall;
    hz.ifIdWrite   = !reset && !stall;
    hz.idExSyncClr = !reset && stall;
    hz.ifIdSyncClr = !reset && flush;
    hz.mdBusy      = !reset && (state == BUSY);
    hz.stateOut    = reset ? 2'd0 : state;
  end

  // Mult/div tracker next state: issue only from IDLE and not under load-use.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      IDLE: begin
        if (hz.idMdStart && !loadUse) begin
          stateNext = BUSY;
          cntNext   = MD_LOAD;
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          stateNext = IDLE;
        end else begin
          cntNext = cnt - 4'd1;
        end
      end
      default: begin
        stateNext = IDLE;
        cntNext   = 4'd0;
      end
    endcase
  end

  // Mult/div tracker state register; reset aborts any in-flight operation.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

`ifdef HAZARD_STATS_EN
  // Saturating statistics counters for stall and flush cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stallCount <= '0;
      flushCount <= '0;
    end else begin
      if (stall && (stallCount != {CNT_W{1'b1}})) begin
        stallCount <= stallCount + CNT_W'(1);
      end
      if (flush && (flushCount != {CNT_W{1'b1}})) begin
        flushCount <= flushCount + CNT_W'(1);
      end
    end
  end
`else
  localparam int unusedCntW = CNT_W;
`endif

endmodule
